// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch controller states
//   INSTR_BYTES   : bytes per instruction word (PC step)
//   OPC_HALT      : opcode that parks the unit when halt detection is built in
//   OPCODE_LSB/LEN: location of the opcode field inside an instruction
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        FAULT  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;
    localparam logic [6:0] OPC_HALT = 7'h7F;
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_LEN = 7;

endpackage

// File: rtl/fetch_unit_if.sv
// IF/ID handshake bundle between the fetch stage and decode.
//   id_valid : IF/ID register holds a valid instruction (fetch -> decode)
//   id_ready : decode accepts this cycle (decode -> fetch)
//   id_instr : captured instruction word
//   id_pc    : byte address of id_instr
// master = fetch side, slave = decode side.
interface fetch_unit_if #(
    parameter int W      = 32,
    parameter int PC_LEN = 32
) ();

    logic              id_valid;
    logic              id_ready;
    logic [W-1:0]      id_instr;
    logic [PC_LEN-1:0] id_pc;

    modport master (
        output id_valid,
        output id_instr,
        output id_pc,
        input  id_ready
    );

    modport slave (
        input  id_valid,
        input  id_instr,
        input  id_pc,
        output id_ready
    );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: holds the instruction handed to decode.
//   clk, rst        : clock, asynchronous active-high reset
//   load            : capture instr_in/pc_in and mark valid
//   flush           : drop the valid flag (wins over load)
//   instr_in, pc_in : word and address being captured
//   valid, instr, pc: register contents
// With neither load nor flush the contents hold, which covers decode stalls.
module if_id_reg #(
    parameter int W      = 32,
    parameter int PC_LEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic [W-1:0]      instr_in,
    input  logic [PC_LEN-1:0] pc_in,
    output logic              valid,
    output logic [W-1:0]      instr,
    output logic [PC_LEN-1:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            // Data is left in place; only the valid flag matters downstream.
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_in;
            pc    <= pc_in;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction
// memory and feeds decode through the IF/ID register.
//   clk, rst       : clock, asynchronous active-high reset
//   fetch_en       : run enable (leaves IDLE, gates captures in FETCH)
//   imem_addr      : byte address to instruction memory (always the PC)
//   imem_rdata     : combinational read data for imem_addr
//   redirect_valid : one-cycle branch/jump redirect from execute
//   redirect_pc    : redirect target
//   id             : IF/ID handshake (master side)
//   fault, fault_pc: sticky fetch fault and the offending address
//   halted         : parked on a halt opcode (only with FETCH_HALT_DETECT_EN)
//
// Build option FETCH_HALT_DETECT_EN: a captured instruction whose opcode is
// OPC_HALT is delivered, then the unit parks in HALTED until redirect/reset.
//
// state  | meaning
// IDLE   | after reset, waiting for fetch_en; nothing captured
// FETCH  | normal sequential fetch, one word per cycle when decode is ready
// FAULT  | illegal PC seen; output invalid until a legal redirect
// HALTED | halt opcode delivered; PC frozen until redirect
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                W          = 32,
    parameter int                PC_LEN     = 32,
    parameter int                IMEM_BYTES = 128,
    parameter logic [PC_LEN-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic [PC_LEN-1:0] imem_addr,
    input  logic [W-1:0]      imem_rdata,
    input  logic              redirect_valid,
    input  logic [PC_LEN-1:0] redirect_pc,
    fetch_unit_if.master      id,
    output logic              fault,
    output logic [PC_LEN-1:0] fault_pc
`ifdef FETCH_HALT_DETECT_EN
    ,
    output logic              halted
`endif
);

    localparam logic [PC_LEN-1:0] LAST_PC  = PC_LEN'(IMEM_BYTES - INSTR_BYTES);
    localparam logic [PC_LEN-1:0] PC_STEP  = PC_LEN'(INSTR_BYTES);

    fetch_state_t      state_q, state_d;
    logic [PC_LEN-1:0] pc_q, pc_d;
    logic [PC_LEN-1:0] fault_pc_q, fault_pc_d;
    logic              load, flush;
    logic              slot_free;
    logic              pc_legal;

    function automatic logic legal_addr(input logic [PC_LEN-1:0] a);
        return (a[1:0] == 2'b00) && (a <= LAST_PC);
    endfunction

    assign slot_free = !id.id_valid || id.id_ready;
    assign pc_legal  = legal_addr(pc_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        load       = 1'b0;
        flush      = 1'b0;

        if (state_q == IDLE) begin
            if (fetch_en) begin
                state_d = FETCH;
            end
        end else if (redirect_valid) begin
            // Redirect beats capture and stall; the held word is wrong-path.
            flush = 1'b1;
            pc_d  = redirect_pc;
            if (legal_addr(redirect_pc)) begin
                state_d = FETCH;
            end else begin
                state_d    = FAULT;
                fault_pc_d = redirect_pc;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (!pc_legal) begin
                        // Faults even when stalled; the held word is dropped.
                        state_d    = FAULT;
                        fault_pc_d = pc_q;
                        flush      = 1'b1;
                    end else if (slot_free) begin
                        if (fetch_en) begin
                            load = 1'b1;
                            pc_d = pc_q + PC_STEP;
`ifdef FETCH_HALT_DETECT_EN
                            if (imem_rdata[OPCODE_LSB +: OPCODE_LEN] == OPC_HALT) begin
                                state_d = HALTED;
                            end
`endif
                        end else begin
                            flush = 1'b1;
                        end
                    end
                end
                FAULT: begin
                    flush = 1'b1;
                end
                HALTED: begin
                    // Let the halt instruction drain, then stay empty.
                    if (slot_free) begin
                        flush = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    if_id_reg #(
        .W      (W),
        .PC_LEN (PC_LEN)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .flush    (flush),
        .instr_in (imem_rdata),
        .pc_in    (pc_q),
        .valid    (id.id_valid),
        .instr    (id.id_instr),
        .pc       (id.id_pc)
    );

    assign imem_addr = pc_q;
    assign fault     = (state_q == FAULT);
    assign fault_pc  = fault_pc_q;
`ifdef FETCH_HALT_DETECT_EN
    assign halted    = (state_q == HALTED);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int MEMB = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;
    logic [31:0] fault_pc;
`ifdef FETCH_HALT_DETECT_EN
    logic        halted;
`endif

    fetch_unit_if #(.W(32), .PC_LEN(32)) id_bus ();

    fetch_unit #(
        .W          (32),
        .PC_LEN     (32),
        .IMEM_BYTES (MEMB),
        .RESET_PC   (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id             (id_bus),
        .fault          (fault),
        .fault_pc       (fault_pc)
`ifdef FETCH_HALT_DETECT_EN
        ,
        .halted         (halted)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:MEMB-1];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a <= 32'(MEMB - 4))
            return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
        return 32'h0;
    endfunction

    assign imem_rdata = word_at(imem_addr);

    task automatic put_word(input int idx, input logic [31:0] w);
        mem[idx*4]   = w[7:0];
        mem[idx*4+1] = w[15:8];
        mem[idx*4+2] = w[23:16];
        mem[idx*4+3] = w[31:24];
    endtask

    // Reference model: architectural view of the fetch stage.
    logic        m_idle, m_fault, m_halt;
    logic [31:0] m_pc, m_fpc, m_idpc, m_instr;
    logic        m_v;

    function automatic logic legal(input logic [31:0] a);
        return (a % 4 == 0) && (a <= 32'(MEMB - 4));
    endfunction

    task automatic model_reset();
        m_idle = 1; m_fault = 0; m_halt = 0;
        m_pc = 0; m_fpc = 0; m_idpc = 0; m_instr = 0; m_v = 0;
    endtask

    task automatic model_step();
        logic [31:0] w;
        w = word_at(m_pc);
        if (m_idle) begin
            if (fetch_en) m_idle = 0;
        end else if (redirect_valid) begin
            m_v  = 0;
            m_pc = redirect_pc;
            m_halt = 0;
            if (legal(redirect_pc)) begin
                m_fault = 0;
            end else begin
                m_fault = 1;
                m_fpc   = redirect_pc;
            end
        end else if (m_fault) begin
            m_v = 0;
        end else if (m_halt) begin
            if (!m_v || id_bus.id_ready) m_v = 0;
        end else if (!legal(m_pc)) begin
            m_fault = 1;
            m_fpc   = m_pc;
            m_v     = 0;
        end else if (!m_v || id_bus.id_ready) begin
            if (fetch_en) begin
                m_v     = 1;
                m_instr = w;
                m_idpc  = m_pc;
                m_pc    = m_pc + 4;
`ifdef FETCH_HALT_DETECT_EN
                if (w[6:0] == 7'h7F) m_halt = 1;
`endif
            end else begin
                m_v = 0;
            end
        end
    endtask

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".imem_addr"}, imem_addr, m_pc);
        chk({tag, ".id_valid"}, 32'(id_bus.id_valid), 32'(m_v));
        chk({tag, ".id_instr"}, id_bus.id_instr, m_instr);
        chk({tag, ".id_pc"}, id_bus.id_pc, m_idpc);
        chk({tag, ".fault"}, 32'(fault), 32'(m_fault));
        chk({tag, ".fault_pc"}, fault_pc, m_fpc);
`ifdef FETCH_HALT_DETECT_EN
        chk({tag, ".halted"}, 32'(halted), 32'(m_halt));
`endif
    endtask

    // One clock: model predicts from pre-edge inputs, DUT sampled 1 ns later.
    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        rst = 1;
        #1;
        model_reset();
        compare_all("async_rst");
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        rst = 1; fetch_en = 0; redirect_valid = 0; redirect_pc = 0;
        id_bus.id_ready = 0;
        for (int i = 0; i < MEMB / 4; i++)
            put_word(i, 32'h13 + (32'(i) << 20) + (32'(i) << 7));
        model_reset();
        @(posedge clk);
        #1;
        compare_all("reset");
        rst = 0;

        // Sequential fetch at full rate.
        fetch_en = 1; id_bus.id_ready = 1;
        cycle("leave_idle");
        chk("idle_no_capture", 32'(id_bus.id_valid), 32'd0);
        cycle("seq0");
        chk("seq0_pc", id_bus.id_pc, 32'h0);
        chk("seq0_instr", id_bus.id_instr, 32'h00000013);
        cycle("seq1");
        chk("seq1_pc", id_bus.id_pc, 32'h4);
        chk("seq1_instr", id_bus.id_instr, 32'h00100093);
        cycle("seq2");
        chk("seq2_pc", id_bus.id_pc, 32'h8);

        // Decode stall.
        id_bus.id_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cycle("stall");
            chk("stall_addr", imem_addr, 32'd12);
            chk("stall_pc", id_bus.id_pc, 32'h8);
        end
        id_bus.id_ready = 1;
        cycle("release");
        chk("release_pc", id_bus.id_pc, 32'd12);

        // Redirect while stalled.
        id_bus.id_ready = 0;
        cycle("stall2");
        redirect_valid = 1; redirect_pc = 32'h40;
        cycle("redir40");
        chk("redir40_valid", 32'(id_bus.id_valid), 32'd0);
        chk("redir40_addr", imem_addr, 32'h40);
        redirect_valid = 0; id_bus.id_ready = 1;
        cycle("after_redir40");
        chk("after_redir40_pc", id_bus.id_pc, 32'h40);

        // Misaligned redirect faults, legal redirect recovers.
        redirect_valid = 1; redirect_pc = 32'h42;
        cycle("redir42");
        chk("redir42_fault", 32'(fault), 32'd1);
        chk("redir42_fpc", fault_pc, 32'h42);
        redirect_valid = 0;
        cycle("fault_hold");
        redirect_valid = 1; redirect_pc = 32'h10;
        cycle("redir10");
        chk("redir10_fault", 32'(fault), 32'd0);
        redirect_valid = 0;
        cycle("after_redir10");
        chk("after_redir10_pc", id_bus.id_pc, 32'h10);

        // Run off the end of memory.
        redirect_valid = 1; redirect_pc = 32'h70;
        cycle("redir70");
        redirect_valid = 0;
        for (int i = 0; i < 4; i++) cycle("tail");
        chk("last_word_pc", id_bus.id_pc, 32'd124);
        chk("last_word_valid", 32'(id_bus.id_valid), 32'd1);
        cycle("end_fault");
        chk("end_fault", 32'(fault), 32'd1);
        chk("end_fault_pc", fault_pc, 32'd128);

        // fetch_en drop and resume.
        redirect_valid = 1; redirect_pc = 32'h20;
        cycle("redir20");
        redirect_valid = 0;
        cycle("run20");
        fetch_en = 0;
        cycle("drain");
        cycle("drained");
        chk("drained_valid", 32'(id_bus.id_valid), 32'd0);
        fetch_en = 1;
        cycle("resume");
        chk("resume_pc", id_bus.id_pc, 32'h24);

        // Reset mid-stream.
        do_reset();
        chk("rst_valid", 32'(id_bus.id_valid), 32'd0);
        cycle("post_rst_idle");

`ifdef FETCH_HALT_DETECT_EN
        put_word(2, 32'h0000007F);
        cycle("h0");
        cycle("h1");
        cycle("h2");
        chk("halt_word_pc", id_bus.id_pc, 32'h8);
        cycle("h3");
        chk("halted", 32'(halted), 32'd1);
        chk("halt_addr", imem_addr, 32'd12);
        cycle("h4");
        chk("halt_addr_frozen", imem_addr, 32'd12);
        put_word(2, 32'h13 + (32'd2 << 20) + (32'd2 << 7));
        do_reset();
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < MEMB; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < MEMB / 4; i++)
            if ($urandom_range(0, 7) == 0) mem[i*4] = 8'h7F;
        for (int n = 0; n < 800; n++) begin
            fetch_en        = ($urandom_range(0, 7) != 0);
            id_bus.id_ready = ($urandom_range(0, 2) != 0);
            redirect_valid  = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0, 1:    redirect_pc = 32'($urandom_range(0, MEMB / 4 - 1)) * 4;
                2:       redirect_pc = 32'($urandom_range(0, MEMB - 1)) | 32'h1;
                default: redirect_pc = 32'($urandom_range(MEMB, 400));
            endcase
            if ($urandom_range(0, 199) == 0) begin
                redirect_valid = 0;
                do_reset();
            end else begin
                cycle("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Upstream stage of the byte-addressed, little-endian, combinational instruction memory.
- Owns the program counter, drives the fetch address, and captures the returned 32-bit word into an IF/ID output register.
- Presents that register to decode through a valid/ready handshake.
- Handles stall, branch/jump redirect, and out-of-range/misaligned fetch faults.

Parameters:
- W, 32, instruction width in bits.
- PC_LEN, 32, PC/address width.
- IMEM_BYTES, 128, instruction memory depth in bytes; legal PC range is 0..IMEM_BYTES-4.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- fetch_en  in  1  run enable; leaves IDLE, and gates new captures while in FETCH.
- imem_addr  out  PC_LEN  byte address to instruction memory; always equals pc.
- imem_rdata  in  W  combinational read data for imem_addr.
- redirect_valid  in  1  one-cycle redirect request from execute.
- redirect_pc  in  PC_LEN  redirect target.
- id_valid  out  1  IF/ID register holds a valid instruction.
- id_ready  in  1  decode accepts this cycle.
- id_instr  out  W  captured instruction.
- id_pc  out  PC_LEN  PC of id_instr.
- fault  out  1  sticky fetch fault.
- fault_pc  out  PC_LEN  offending PC.

Behaviour:
- Reset values:
  - pc = RESET_PC; state = IDLE.
  - id_valid = 0; id_instr = 0; id_pc = 0.
  - fault = 0; fault_pc = 0.
  - Reset mid-operation discards all in-flight state immediately.
- States:
  - IDLE: no capture. Moves to FETCH on the edge where fetch_en = 1.
  - FETCH: normal operation (rules below).
  - FAULT: id_valid forced 0; fault = 1. Exits only on redirect_valid with a legal target (-> FETCH, pc = target, fault cleared) or on reset.
- Slot free: slot_free = !id_valid || id_ready.
- Capture in FETCH, when slot_free && fetch_en && !redirect_valid && pc is legal:
  - id_instr <= imem_rdata; id_pc <= pc; id_valid <= 1; pc <= pc + 4.
  - Latency: instruction at pc appears on id_* one cycle after the capture edge.
  - Sustains 1 instruction/cycle when id_ready is held at 1.
- Drain: if slot_free but no capture occurs (fetch_en = 0), id_valid <= 0. pc holds.
- Stall: id_valid && !id_ready holds id_*, pc, and state unchanged.
- Redirect (priority over capture and stall, in any state except IDLE):
  - id_valid <= 0 (flush, regardless of id_ready).
  - pc <= redirect_pc. No capture in that cycle.
  - Illegal target -> FAULT, with fault_pc = redirect_pc.
- Legal PC: pc[1:0] == 0 && pc <= IMEM_BYTES-4.
  - Checked before capture. An illegal pc in FETCH -> FAULT with fault_pc = pc, no capture.
  - A valid id_* register already held is dropped.
- Wrap: pc + 4 is computed modulo 2^PC_LEN, but the legality check faults before any wrap can occur.
- Boundary: the last legal word (pc = IMEM_BYTES-4) is captured normally. The next cycle faults at pc = IMEM_BYTES.
- fetch_en falling mid-run: the held instruction is still delivered; no new capture. fetch_en rising again resumes at the current pc.

Optional Feature:
- Macro: FETCH_HALT_DETECT_EN.
- Defined:
  - A captured instruction with opcode bits [6:0] == OPC_HALT (7'h7F) is delivered normally.
  - The unit then enters state HALTED: no further captures, pc frozen at halt PC + 4, output halted = 1 (extra port, reset 0).
  - Exit HALTED only via redirect (same legality rules) or reset.
- Not defined: no HALTED state and no halted port; 7'h7F is treated as an ordinary instruction.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum: IDLE, FETCH, FAULT, HALTED.
  - INSTR_BYTES = 4.
  - OPC_HALT = 7'h7F.
  - OPCODE_LSB = 0, OPCODE_LEN = 7.
- Sub-module if_id_reg: holds id_valid/id_instr/id_pc with load, flush, and hold controls. The FSM and PC logic stay in fetch_unit.

Test Plan:
- Reset, fetch_en = 1, id_ready = 1, memory words 0x00000013, 0x00100093, ... -> id_pc = 0, 4, 8 on consecutive cycles, id_valid continuous, id_instr matches the little-endian bytes.
- id_ready = 0 for 3 cycles with id_pc = 8 -> id_instr/id_pc held, imem_addr stays 12; on release, id_pc = 12 one cycle later.
- redirect_valid with redirect_pc = 0x40 while stalled -> next cycle id_valid = 0, imem_addr = 0x40; following cycle id_pc = 0x40.
- redirect_pc = 0x42 -> FAULT, fault = 1, fault_pc = 0x42; then redirect_pc = 0x10 -> fault = 0, id_pc = 0x10 next.
- Sequential fetch to pc = 124 with IMEM_BYTES = 128 -> word at 124 delivered, then fault = 1 with fault_pc = 128.
- Assert rst mid-stream with id_valid = 1 -> all outputs zero immediately, pc = RESET_PC. With FETCH_HALT_DETECT_EN and word 0x0000007F at 8 -> halted = 1 after delivery, imem_addr frozen at 12.
